// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic lab blocks.
package arith_pkg;

  // Default operand width for the lab datapaths.
  localparam int unsigned ARITH_WIDTH = 8;

  // Sequencing states of the bit-serial arithmetic units.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } arith_state_e;

  // Signed overflow of a subtraction: the operands had opposite signs and the
  // result sign differs from the minuend sign.
  function automatic logic sub_signed_ovf(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  // Borrow when b exceeds a, or when a == b and a borrow is coming in.
  always_comb begin
    d_o    = a_i ^ b_i ^ bin_i;
    bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor behind a start/done handshake. Computes a - b - bin
// one bit per clock, LSB first, and registers diff/bout/ovf on completion.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  arith_state_e     state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 already-computed low bits; the final bit comes straight
  // from the cell on the completing edge.
  logic [WIDTH-2:0] d_sh_q, d_sh_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             bit_d;
  logic             brw_n;
  logic [WIDTH-1:0] shifted;

  full_subtractor u_cell (
    .a_i   (a_sh_q[0]),
    .b_i   (b_sh_q[0]),
    .bin_i (brw_q),
    .d_o   (bit_d),
    .bout_o(brw_n)
  );

  // New bit enters at the top; after WIDTH bits this is the full result.
  assign shifted = {bit_d, d_sh_q};

  // Next-state: operand load, per-bit shifting and result capture.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        d_sh_d = shifted[WIDTH-1:1];
        brw_d  = brw_n;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LastBit) begin
          diff_d  = shifted;
          bout_d  = brw_n;
          ovf_d   = sub_signed_ovf(a_msb_q, b_msb_q, bit_d);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status decode and registered results.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    diff = diff_q;
    bout = bout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mbin, output logic [W-1:0] md,
                                output logic mbo, output logic mov);
    longint ua, ub, sa, sb, r;
    ua  = longint'(ma);
    ub  = longint'(mb);
    md  = W'(ua - ub - longint'(mbin));
    mbo = (ua < ub + longint'(mbin));
    sa  = ma[W-1] ? ua - (longint'(1) << W) : ua;
    sb  = mb[W-1] ? ub - (longint'(1) << W) : ub;
    r   = sa - sb - longint'(mbin);
    mov = (r < -(longint'(1) << (W - 1))) || (r > (longint'(1) << (W - 1)) - 1);
  endfunction

  // Issue one operation from IDLE; report latency (-1 on timeout), results,
  // and done/busy one edge after completion.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       output int lat, output logic [W-1:0] od, output logic obo,
                       output logic oov, output logic done_after, output logic busy_after);
    a = oa; b = ob; bin = obin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= W + 4; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    od = diff; obo = bout; oov = ovf;
    @(posedge clk); #1;
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (diff !== '0) begin n_fail++; $display("FAIL reset_diff: got %h want 00", diff); end
    n_tests++; if (bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout: got %b want 0", bout); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      @(posedge clk); #1;
      n_tests++;
      if ({busy, done, diff, bout, ovf} !== '0) begin
        n_fail++;
        $display("FAIL idle_quiet cycle %0d: got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
                 i, busy, done, diff, bout, ovf);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [8] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h80};
    logic [W-1:0] vb [8] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h7F};
    logic         vc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    logic [W-1:0] od, ed;
    logic obo, oov, eb, eo, dn, bz;
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], vc[i], lat, od, obo, oov, dn, bz);
      model(va[i], vb[i], vc[i], ed, eb, eo);
      n_tests++; if (lat !== W) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, W); end
      n_tests++; if (od !== ed) begin n_fail++; $display("FAIL dir%0d_diff: got %h want %h", i, od, ed); end
      n_tests++; if (obo !== eb) begin n_fail++; $display("FAIL dir%0d_bout: got %b want %b", i, obo, eb); end
      n_tests++; if (oov !== eo) begin n_fail++; $display("FAIL dir%0d_ovf: got %b want %b", i, oov, eo); end
      n_tests++; if (dn !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_fall: got %b want 0", i, dn); end
      n_tests++; if (bz !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_fall: got %b want 0", i, bz); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] ra, rb, od, ed;
    logic rc, obo, oov, eb, eo, dn, bz;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      do_op(ra, rb, rc, lat, od, obo, oov, dn, bz);
      model(ra, rb, rc, ed, eb, eo);
      n_tests++;
      if (lat !== W || od !== ed || obo !== eb || oov !== eo || dn !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d %h-%h-%b: got lat=%0d diff=%h bout=%b ovf=%b done+1=%b want lat=%0d diff=%h bout=%b ovf=%b done+1=0",
                 i, ra, rb, rc, lat, od, obo, oov, dn, W, ed, eb, eo);
      end
    end
  endtask

  // start held high, operands changing every cycle: accepts every W+2 edges.
  task automatic test_back_to_back();
    logic [W-1:0] qa[$], qb[$], ed, ca, cb;
    logic qc[$], cc, eb, eo, exp_done;
    int qdone[$];
    int next_acc = 0;
    int n_cyc = 5 * (W + 2);
    for (int e = 0; e < n_cyc; e++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom); start = 1'b1;
      if (e == next_acc) begin
        qa.push_back(a); qb.push_back(b); qc.push_back(bin);
        qdone.push_back(e + W);
        next_acc = e + W + 2;
      end
      @(posedge clk); #1;
      exp_done = (qdone.size() > 0) && (qdone[0] == e);
      n_tests++;
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL b2b_done edge %0d: got %b want %b", e, done, exp_done);
      end
      if (exp_done) begin
        ca = qa.pop_front(); cb = qb.pop_front(); cc = qc.pop_front();
        void'(qdone.pop_front());
        model(ca, cb, cc, ed, eb, eo);
        n_tests++;
        if (diff !== ed || bout !== eb || ovf !== eo) begin
          n_fail++;
          $display("FAIL b2b_result %h-%h-%b: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                   ca, cb, cc, diff, bout, ovf, ed, eb, eo);
        end
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_busy: got %b want 0", busy); end
  endtask

  // A start pulse during RUN must not disturb the operation in flight.
  task automatic test_mid_start();
    logic [W-1:0] ed;
    logic eb, eo;
    int lat = -1;
    model(8'h3C, 8'h15, 1'b0, ed, eb, eo);
    a = 8'h3C; b = 8'h15; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a = 8'hAA; b = W'($urandom); bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 5; i <= W + 4; i++) begin
      if (done) begin
        lat = i - 1;
        break;
      end
      @(posedge clk); #1;
    end
    n_tests++; if (lat !== W) begin n_fail++; $display("FAIL mid_start_latency: got %0d want %0d", lat, W); end
    n_tests++;
    if (diff !== ed || bout !== eb || ovf !== eo) begin
      n_fail++;
      $display("FAIL mid_start_result: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
               diff, bout, ovf, ed, eb, eo);
    end
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_start_idle: got busy=%b want 0", busy); end
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_start_not_queued cycle %0d: got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [W-1:0] od;
    logic obo, oov, dn, bz;
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
               busy, done, diff, bout, ovf);
    end
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b0 || diff !== '0) begin
        n_fail++;
        $display("FAIL abort_no_done cycle %0d: got done=%b diff=%h want 0 00", i, done, diff);
      end
    end
    do_op(8'h10, 8'h01, 1'b0, lat, od, obo, oov, dn, bz);
    n_tests++;
    if (lat !== W || od !== 8'h0F || obo !== 1'b0 || oov !== 1'b0) begin
      n_fail++;
      $display("FAIL after_abort: got lat=%0d diff=%h bout=%b ovf=%b want lat=%0d diff=0f bout=0 ovf=0",
               lat, od, obo, oov, W);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
